// File: rtl/piece_motion_if.sv
// Bundle between the falling-piece controller and its neighbours: keycode and
// board collision status come in, piece origin and status flags go out.
// master = the motion controller, slave = keycode decoder / board side.
interface piece_motion_if #(
    parameter int COLS = 10,
    parameter int ROWS = 20
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [7:0]    keycode;
    logic          collide_left;
    logic          collide_right;
    logic          collide_down;
    logic          spawn_blocked;
    logic          lock_ack;
    logic [CW-1:0] piece_col;
    logic [RW-1:0] piece_row;
    logic          rotate_req;
    logic          lock_pulse;
    logic          active;
    logic          game_over;

    modport master (
        input  keycode, collide_left, collide_right, collide_down, spawn_blocked, lock_ack,
        output piece_col, piece_row, rotate_req, lock_pulse, active, game_over
    );

    modport slave (
        output keycode, collide_left, collide_right, collide_down, spawn_blocked, lock_ack,
        input  piece_col, piece_row, rotate_req, lock_pulse, active, game_over
    );
endinterface

// File: rtl/piece_motion_ctrl.sv
// Grid-based falling-piece motion controller. Tracks the active piece origin in
// board cells and applies gravity, soft/hard drop, DAS/ARR horizontal auto-repeat,
// lock delay, respawn and game-over. Collision status is supplied by the board
// logic each frame; this block never looks at the board itself.
module piece_motion_ctrl #(
    parameter int         COLS           = 10,
    parameter int         ROWS           = 20,
    parameter int         SPAWN_COL      = 4,
    parameter int         SPAWN_ROW      = 0,
    parameter int         GRAVITY_FRAMES = 30,
    parameter int         SOFT_FRAMES    = 3,
    parameter int         DAS_FRAMES     = 10,
    parameter int         ARR_FRAMES     = 3,
    parameter int         LOCK_FRAMES    = 15,
    parameter logic [7:0] KEY_LEFT       = 8'h04,
    parameter logic [7:0] KEY_RIGHT      = 8'h07,
    parameter logic [7:0] KEY_SOFT       = 8'h16,
    parameter logic [7:0] KEY_ROT        = 8'h1A,
    parameter logic [7:0] KEY_HARD       = 8'h2C,
    parameter logic [7:0] KEY_RESPAWN    = 8'h19
) (
    input  logic          frame_clk,
    input  logic          Reset,
    piece_motion_if.master bus
);
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);
    localparam int G_MAX  = (GRAVITY_FRAMES > SOFT_FRAMES) ? GRAVITY_FRAMES : SOFT_FRAMES;
    localparam int D_MAX  = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
    localparam int GW     = $clog2(G_MAX + 1);
    localparam int DW     = $clog2(D_MAX + 1);
    localparam int LW     = $clog2(LOCK_FRAMES + 1);

    localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_FRAMES - 1);
    localparam logic [GW-1:0] SOFT_LAST = GW'(SOFT_FRAMES - 1);
    localparam logic [DW-1:0] DAS_LAST  = DW'(DAS_FRAMES - 1);
    localparam logic [DW-1:0] ARR_LAST  = DW'(ARR_FRAMES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FRAMES - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
    localparam logic [CW-1:0] SPAWN_C   = CW'(SPAWN_COL);
    localparam logic [RW-1:0] SPAWN_R   = RW'(SPAWN_ROW);

    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_FALL,
        ST_LOCK_WAIT,
        ST_LOCKED,
        ST_GAMEOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [GW-1:0] grav_q, grav_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [DW-1:0] das_q, das_d;
    logic          rep_q, rep_d;
    logic [7:0]    key_prev_q, key_prev_d;
    logic          rotate_q, rotate_d;
    logic          lock_pulse_q, lock_pulse_d;

    logic          key_lr;
    logic          h_fire;
    logic          h_ok;
    logic [CW-1:0] h_col;
    logic          grounded;
    logic [GW-1:0] period_last;
    logic          go_spawn;

    // State register and all tracked state, synchronous reset to the spawn origin.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= ST_SPAWN;
            col_q        <= SPAWN_C;
            row_q        <= SPAWN_R;
            grav_q       <= '0;
            lock_q       <= '0;
            das_q        <= '0;
            rep_q        <= 1'b0;
            key_prev_q   <= 8'h00;
            rotate_q     <= 1'b0;
            lock_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            grav_q       <= grav_d;
            lock_q       <= lock_d;
            das_q        <= das_d;
            rep_q        <= rep_d;
            key_prev_q   <= key_prev_d;
            rotate_q     <= rotate_d;
            lock_pulse_q <= lock_pulse_d;
        end
    end

    // Horizontal auto-repeat: fire on press edge, then after DAS, then every ARR.
    // Timing keeps running even when the move itself is blocked.
    always_comb begin
        das_d  = '0;
        rep_d  = 1'b0;
        h_fire = 1'b0;
        key_lr = (bus.keycode == KEY_LEFT) || (bus.keycode == KEY_RIGHT);
        if (((state_q == ST_FALL) || (state_q == ST_LOCK_WAIT)) && key_lr) begin
            if (bus.keycode != key_prev_q) begin
                h_fire = 1'b1;
            end else if (das_q >= (rep_q ? ARR_LAST : DAS_LAST)) begin
                h_fire = 1'b1;
                rep_d  = 1'b1;
            end else begin
                das_d = das_q + 1'b1;
                rep_d = rep_q;
            end
        end
        h_ok  = h_fire &&
                (((bus.keycode == KEY_LEFT)  && !bus.collide_left  && (col_q != '0)) ||
                 ((bus.keycode == KEY_RIGHT) && !bus.collide_right && (col_q != COL_MAX)));
        h_col = (bus.keycode == KEY_LEFT) ? (col_q - 1'b1) : (col_q + 1'b1);
    end

    // Next-state, position and counter update; one action per frame in FALL.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        grav_d      = grav_q;
        lock_d      = lock_q;
        go_spawn    = 1'b0;
        key_prev_d  = bus.keycode;
        // The bottom row is a floor even if the board forgets to say so.
        grounded    = bus.collide_down || (row_q == ROW_MAX);
        period_last = (bus.keycode == KEY_SOFT) ? SOFT_LAST : GRAV_LAST;

        case (state_q)
            ST_SPAWN: begin
                col_d   = SPAWN_C;
                row_d   = SPAWN_R;
                grav_d  = '0;
                state_d = bus.spawn_blocked ? ST_GAMEOVER : ST_FALL;
            end
            ST_FALL: begin
                if (bus.keycode == KEY_RESPAWN) begin
                    go_spawn = 1'b1;
                end else if (bus.keycode == KEY_HARD) begin
                    if (grounded) begin
                        state_d = ST_LOCKED;
                    end else begin
                        row_d  = row_q + 1'b1;
                        grav_d = '0;
                    end
                end else begin
                    if (h_ok) begin
                        col_d = h_col;
                    end
                    // A horizontal move owns the frame: gravity waits at terminal.
                    if (grav_q < period_last) begin
                        grav_d = grav_q + 1'b1;
                    end else if (!h_ok) begin
                        if (grounded) begin
                            state_d = ST_LOCK_WAIT;
                            lock_d  = '0;
                        end else begin
                            row_d  = row_q + 1'b1;
                            grav_d = '0;
                        end
                    end
                end
            end
            ST_LOCK_WAIT: begin
                if (bus.keycode == KEY_RESPAWN) begin
                    go_spawn = 1'b1;
                end else if (!grounded) begin
                    state_d = ST_FALL;
                    grav_d  = '0;
                    if (h_ok) begin
                        col_d = h_col;
                    end
                end else if (lock_q >= LOCK_LAST) begin
                    // Freeze the column on the lock frame so the merge matches the checked cells.
                    state_d = ST_LOCKED;
                end else begin
                    lock_d = lock_q + 1'b1;
                    if (h_ok) begin
                        col_d = h_col;
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.lock_ack) begin
                    go_spawn = 1'b1;
                end
            end
            ST_GAMEOVER: begin
                if (bus.keycode == KEY_RESPAWN) begin
                    go_spawn = 1'b1;
                end
            end
            default: begin
                go_spawn = 1'b1;
            end
        endcase

        if (go_spawn) begin
            state_d = ST_SPAWN;
            col_d   = SPAWN_C;
            row_d   = SPAWN_R;
            grav_d  = '0;
            lock_d  = '0;
        end

        lock_pulse_d = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
        rotate_d     = ((state_q == ST_FALL) || (state_q == ST_LOCK_WAIT)) &&
                       (bus.keycode == KEY_ROT) && (key_prev_q != KEY_ROT);
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus.piece_col  = col_q;
        bus.piece_row  = row_q;
        bus.rotate_req = rotate_q;
        bus.lock_pulse = lock_pulse_q;
        bus.active     = (state_q == ST_FALL) || (state_q == ST_LOCK_WAIT);
        bus.game_over  = (state_q == ST_GAMEOVER);
    end
endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Bench for piece_motion_ctrl: directed scenarios followed by randomized key and
// board stimulus, with a behavioural reference model feeding a scoreboard queue.
module tb_piece_motion_ctrl;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int SPAWN_COL = 4;
    localparam int SPAWN_ROW = 0;
    localparam int GRAV = 30;
    localparam int SOFT = 3;
    localparam int DAS = 10;
    localparam int ARR = 3;
    localparam int LOCK = 15;
    localparam logic [7:0] K_LEFT = 8'h04, K_RIGHT = 8'h07, K_SOFT = 8'h16;
    localparam logic [7:0] K_ROT = 8'h1A, K_HARD = 8'h2C, K_RESP = 8'h19;

    logic frame_clk = 1'b0;
    logic Reset;
    always #5 frame_clk = ~frame_clk;

    piece_motion_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    piece_motion_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    typedef struct packed {
        logic [3:0] col;
        logic [4:0] row;
        logic       rot;
        logic       lp;
        logic       act;
        logic       go;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passed = 0;

    typedef enum int {M_SPAWN, M_FALL, M_GROUNDED, M_LOCKED, M_OVER} mstate_e;
    mstate_e    m_st;
    int         m_col, m_row, m_grav, m_lock, m_held;
    logic [7:0] m_prev;
    bit         m_rot, m_lp;

    int g_floor = 99;
    int g_lwall = -1;
    int g_rwall = 99;
    bit g_noise = 1'b0;

    task automatic spawn_load();
        m_col = SPAWN_COL; m_row = SPAWN_ROW; m_grav = 0; m_lock = 0; m_held = 0;
    endtask

    // Reference: applies one frame of the motion rules to the model state.
    task automatic model_step(input logic [7:0] k, input bit cl, input bit cr, input bit cd,
                              input bit sb, input bit ack, input bit rst);
        bit grounded, fire, moved, to_spawn, playing, rot;
        int target, period, ncol;
        mstate_e nst;
        if (rst) begin
            spawn_load(); m_st = M_SPAWN; m_prev = 8'h00; m_rot = 0; m_lp = 0;
            return;
        end
        playing  = (m_st == M_FALL) || (m_st == M_GROUNDED);
        grounded = cd || (m_row == ROWS - 1);
        rot      = playing && (k == K_ROT) && (m_prev != K_ROT);
        fire = 0; moved = 0; ncol = m_col;
        if (playing && (k == K_LEFT || k == K_RIGHT)) begin
            // m_held = frames since the press; moves at 0, DAS, DAS+ARR, DAS+2*ARR ...
            if (k != m_prev) begin m_held = 0; fire = 1; end
            else begin
                m_held++;
                fire = (m_held == DAS) || (m_held > DAS && ((m_held - DAS) % ARR) == 0);
            end
            if (fire) begin
                target = m_col + ((k == K_LEFT) ? -1 : 1);
                if (!((k == K_LEFT) ? cl : cr) && target >= 0 && target < COLS) begin
                    ncol = target; moved = 1;
                end
            end
        end else begin
            m_held = 0;
        end
        nst = m_st; to_spawn = 0;
        case (m_st)
            M_SPAWN: begin nst = sb ? M_OVER : M_FALL; m_grav = 0; end
            M_FALL: begin
                if (k == K_RESP) to_spawn = 1;
                else if (k == K_HARD) begin
                    if (grounded) nst = M_LOCKED;
                    else begin m_row++; m_grav = 0; end
                end else begin
                    m_col = ncol;
                    period = (k == K_SOFT) ? SOFT : GRAV;
                    if (m_grav < period - 1) m_grav++;
                    else if (!moved) begin
                        if (grounded) begin nst = M_GROUNDED; m_lock = 0; end
                        else begin m_row++; m_grav = 0; end
                    end
                end
            end
            M_GROUNDED: begin
                if (k == K_RESP) to_spawn = 1;
                else if (!grounded) begin nst = M_FALL; m_grav = 0; m_col = ncol; end
                else if (m_lock == LOCK - 1) nst = M_LOCKED;
                else begin m_lock++; m_col = ncol; end
            end
            M_LOCKED: if (ack) to_spawn = 1;
            M_OVER:   if (k == K_RESP) to_spawn = 1;
            default: ;
        endcase
        if (to_spawn) begin nst = M_SPAWN; spawn_load(); end
        m_lp   = (nst == M_LOCKED) && (m_st != M_LOCKED);
        m_rot  = rot;
        m_prev = k;
        m_st   = nst;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.col = 4'(m_col);
        e.row = 5'(m_row);
        e.rot = m_rot;
        e.lp  = m_lp;
        e.act = (m_st == M_FALL) || (m_st == M_GROUNDED);
        e.go  = (m_st == M_OVER);
        return e;
    endfunction

    // Drive one frame of stimulus, push the expected outputs, wait past the edge.
    task automatic tick(input logic [7:0] k, input bit sb, input bit ack, input bit rst);
        bit cl, cr, cd;
        cd = (m_row >= g_floor);
        cl = (m_col <= g_lwall);
        cr = (m_col >= g_rwall);
        if (g_noise && $urandom_range(0, 15) == 0) cd = ~cd;
        Reset             = rst;
        bus.keycode       = k;
        bus.collide_left  = cl;
        bus.collide_right = cr;
        bus.collide_down  = cd;
        bus.spawn_blocked = sb;
        bus.lock_ack      = ack;
        model_step(k, cl, cr, cd, sb, ack, rst);
        exp_q.push_back(model_out());
        @(posedge frame_clk);
        #2;
    endtask

    task automatic dchk(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Monitor: pops one expectation per frame and compares all outputs.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {bus.piece_col, bus.piece_row, bus.rotate_req, bus.lock_pulse,
                       bus.active, bus.game_over};
                checks++;
                if (got === e) passed++;
                else $display("FAIL frame_outputs t=%0t: got col=%0d row=%0d rot=%0b lp=%0b act=%0b go=%0b, want col=%0d row=%0d rot=%0b lp=%0b act=%0b go=%0b",
                              $time, got.col, got.row, got.rot, got.lp, got.act, got.go,
                              e.col, e.row, e.rot, e.lp, e.act, e.go);
            end
        end
    end

    initial begin
        logic [7:0] key;
        int hold, r;
        // Reset state
        tick(8'h00, 0, 0, 1);
        tick(8'h00, 0, 0, 1);
        dchk("reset_row", int'(bus.piece_row), 0);
        dchk("reset_col", int'(bus.piece_col), 4);
        dchk("reset_active", int'(bus.active), 0);
        dchk("reset_game_over", int'(bus.game_over), 0);

        // Plain gravity: one row per 30 falling frames
        tick(8'h00, 0, 0, 0);
        repeat (29) tick(8'h00, 0, 0, 0);
        dchk("grav_row0_f29", int'(bus.piece_row), 0);
        tick(8'h00, 0, 0, 0);
        dchk("grav_row1_f30", int'(bus.piece_row), 1);
        repeat (30) tick(8'h00, 0, 0, 0);
        dchk("grav_row2_f60", int'(bus.piece_row), 2);
        dchk("grav_col", int'(bus.piece_col), 4);

        // Held LEFT: moves at frames 1, 11, 14, 17 then stops at column 0
        for (int f = 1; f <= 60; f++) begin
            tick(K_LEFT, 0, 0, 0);
            dchk($sformatf("das_col_f%0d", f), int'(bus.piece_col),
                 (f < 11) ? 3 : (f < 14) ? 2 : (f < 17) ? 1 : 0);
        end

        // Hard drop onto a floor at row 12
        tick(8'h00, 0, 0, 1);
        tick(8'h00, 0, 0, 0);
        g_floor = 12;
        repeat (12) tick(K_HARD, 0, 0, 0);
        dchk("hard_row12", int'(bus.piece_row), 12);
        dchk("hard_no_pulse_yet", int'(bus.lock_pulse), 0);
        tick(K_HARD, 0, 0, 0);
        dchk("hard_lock_pulse", int'(bus.lock_pulse), 1);
        dchk("hard_inactive", int'(bus.active), 0);
        tick(8'h00, 0, 0, 0);
        dchk("locked_pulse_once", int'(bus.lock_pulse), 0);
        tick(8'h00, 0, 1, 0);
        dchk("ack_spawn_row", int'(bus.piece_row), 0);
        dchk("ack_spawn_col", int'(bus.piece_col), 4);

        // Lock delay on the bottom row
        g_floor = 99;
        tick(8'h00, 0, 0, 0);
        repeat (19) tick(K_HARD, 0, 0, 0);
        dchk("floor_row19", int'(bus.piece_row), 19);
        repeat (30) tick(8'h00, 0, 0, 0);
        dchk("lockwait_active", int'(bus.active), 1);
        repeat (14) tick(8'h00, 0, 0, 0);
        dchk("lockwait_no_pulse_f14", int'(bus.lock_pulse), 0);
        tick(8'h00, 0, 0, 0);
        dchk("lockwait_pulse_f15", int'(bus.lock_pulse), 1);
        tick(8'h00, 0, 1, 0);
        dchk("lockwait_spawn_row", int'(bus.piece_row), 0);
        dchk("lockwait_spawn_col", int'(bus.piece_col), 4);

        // Lock wait cancelled when the support disappears
        tick(8'h00, 0, 0, 0);
        g_floor = 5;
        repeat (5) tick(K_HARD, 0, 0, 0);
        repeat (30) tick(8'h00, 0, 0, 0);
        repeat (8) tick(8'h00, 0, 0, 0);
        g_floor = 99;
        tick(8'h00, 0, 0, 0);
        dchk("cancel_active", int'(bus.active), 1);
        repeat (29) tick(8'h00, 0, 0, 0);
        dchk("cancel_row5", int'(bus.piece_row), 5);
        tick(8'h00, 0, 0, 0);
        dchk("cancel_row6", int'(bus.piece_row), 6);

        // Game over, ignored keys, respawn, rotate, reset during hard drop
        tick(8'h00, 0, 0, 1);
        tick(8'h00, 1, 0, 0);
        dchk("over_flag", int'(bus.game_over), 1);
        dchk("over_inactive", int'(bus.active), 0);
        repeat (3) tick(K_LEFT, 0, 0, 0);
        tick(K_HARD, 0, 0, 0);
        dchk("over_frozen_col", int'(bus.piece_col), 4);
        dchk("over_frozen_row", int'(bus.piece_row), 0);
        tick(K_RESP, 0, 0, 0);
        dchk("respawn_clears_over", int'(bus.game_over), 0);
        tick(8'h00, 0, 0, 0);
        dchk("respawn_active", int'(bus.active), 1);
        tick(K_ROT, 0, 0, 0);
        dchk("rotate_pulse", int'(bus.rotate_req), 1);
        tick(K_ROT, 0, 0, 0);
        dchk("rotate_once", int'(bus.rotate_req), 0);
        tick(K_RIGHT, 0, 0, 0);
        dchk("right_col5", int'(bus.piece_col), 5);
        repeat (5) tick(K_HARD, 0, 0, 0);
        dchk("hard_row5", int'(bus.piece_row), 5);
        tick(K_HARD, 0, 0, 1);
        dchk("reset_hard_row", int'(bus.piece_row), 0);
        dchk("reset_hard_col", int'(bus.piece_col), 4);

        // Randomized play
        g_noise = 1'b1;
        hold = 0;
        key = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if (m_st == M_SPAWN) begin
                g_floor = $urandom_range(3, 19);
                g_lwall = int'($urandom_range(0, 4)) - 1;
                g_rwall = $urandom_range(6, 10);
            end
            if (hold == 0) begin
                r = $urandom_range(0, 99);
                key = (r < 30) ? 8'h00 : (r < 45) ? K_LEFT : (r < 60) ? K_RIGHT :
                      (r < 73) ? K_SOFT : (r < 83) ? K_ROT : (r < 90) ? K_HARD :
                      (r < 95) ? K_RESP : 8'h33;
                hold = $urandom_range(1, 20);
            end
            hold--;
            tick(key, (m_st == M_SPAWN) && ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 499) == 0);
        end

        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
